// File: rtl/lsu.sv
// lsu: RV32I load/store unit with one memory access in flight over a valid/ready port
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic            wen_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            bad;
    logic [3:0]      wmask;
    logic [XLEN-1:0] wdata_sh;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;

    assign in_ready = (state == IDLE);

    // Decode the incoming op: legality, alignment and store lane placement
    always_comb begin
        bad = (in_wen ? (in_funct3 > 3'd2) : (in_funct3 == 3'd3 || in_funct3[2:1] == 2'b11))
            || (in_funct3[1:0] == 2'b01 && in_addr[0])
            || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
        wmask = !in_wen ? 4'b0000
              : in_funct3[1:0] == 2'b00 ? 4'b0001 << in_addr[1:0]
              : in_funct3[1:0] == 2'b01 ? 4'b0011 << in_addr[1:0]
              : 4'b1111;
        wdata_sh = in_wdata << {in_addr[1:0], 3'b000};
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_v = funct3_q == 3'd0 ? {{24{byte_v[7]}}, byte_v}
               : funct3_q == 3'd4 ? {24'd0, byte_v}
               : funct3_q == 3'd1 ? {{16{half_v[15]}}, half_v}
               : funct3_q == 3'd5 ? {16'd0, half_v}
               : mem_rdata;
    end

    // Transaction FSM; every memory and writeback output is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= 4'd0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    wen_q     <= in_wen;
                    funct3_q  <= in_funct3;
                    off_q     <= in_addr[1:0];
                    mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                    mem_wen   <= in_wen;
                    mem_wdata <= wdata_sh;
                    mem_wmask <= wmask;
                    if (bad) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_rdata <= '0;
                    end else begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                    end
                end
                REQ: if (mem_req_ready) begin
                    state         <= WAIT;
                    mem_req_valid <= 1'b0;
                end
                WAIT: if (mem_rsp_valid) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_err   <= 1'b0;
                    out_rdata <= wen_q ? '0 : load_v;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a spec-level reference model
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wen = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    logic        active = 1'b0;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_wm;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    logic        exp_wen;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: access size, legality, lanes and extension computed arithmetically
    function automatic void model(input logic wen, input logic [2:0] f3,
                                  input logic [31:0] addr, wdata, rdata,
                                  output logic err, output logic [31:0] rd,
                                  output logic [3:0] wm, output logic [31:0] wd);
        int size, off;
        logic legal;
        logic [63:0] mask, raw;
        size  = 1 << f3[1:0];
        off   = int'(addr % 4);
        legal = wen ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || (addr % size != 0);
        mask  = (64'd1 << (8 * size)) - 64'd1;
        raw   = ({32'd0, rdata} >> (8 * off)) & mask;
        if (f3 < 3'd4 && size < 4 && raw[8*size-1]) raw = raw | ~mask;
        rd = (err || wen) ? 32'd0 : raw[31:0];
        wm = wen ? 4'(((1 << size) - 1) << off) : 4'd0;
        wd = 32'({32'd0, wdata} << (8 * off));
    endfunction

    // Every cycle of a transaction: outputs must agree with the reference
    always @(negedge clk) begin
        if (active) begin
            if (exp_err) chk("no_req_on_err", {31'd0, mem_req_valid}, 32'd0);
            else if (mem_req_valid) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
                chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wm});
                if (exp_wen) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (out_valid) begin
                chk("out_rdata", out_rdata, exp_rd);
                chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic run_op(input string n, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, wdata, rdata, lit_rd,
                          input logic lit_err, input logic [3:0] lit_wm, input logic [31:0] lit_wd,
                          input int req_stall, out_stall, input logic stray);
        int cyc, stalls;
        logic hs, seen;
        model(wen, f3, addr, wdata, rdata, exp_err, exp_rd, exp_wm, exp_wd);
        exp_addr = addr & ~32'h3;
        exp_wen = wen;
        hs = 1'b0;
        seen = 1'b0;
        stalls = 0;
        @(negedge clk);
        chk({n, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        active = 1'b1;
        for (cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata = $urandom;
            if (out_valid) break;
            if (hs) begin
                mem_rsp_valid = 1'b1; mem_rdata = rdata; hs = 1'b0;
            end else if (mem_req_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({n, "_wmask"}, {28'd0, mem_wmask}, {28'd0, lit_wm});
                    if (wen) chk({n, "_wdata"}, mem_wdata, lit_wd);
                end
                if (stalls < req_stall) begin
                    stalls++;
                    chk({n, "_busy_req"}, {31'd0, in_ready}, 32'd0);
                end else begin
                    mem_req_ready = 1'b1; hs = 1'b1;
                end
            end
        end
        chk({n, "_latency"}, cyc, lit_err ? 32'd1 : 32'(3 + req_stall));
        chk({n, "_rdata"}, out_rdata, lit_rd);
        chk({n, "_err"}, {31'd0, out_err}, {31'd0, lit_err});
        chk({n, "_req_issued"}, {31'd0, seen}, {31'd0, !lit_err});
        out_ready = (out_stall == 0);
        mem_rsp_valid = stray && out_stall > 0;
        mem_rdata = ~rdata;
        for (int i = 1; i <= out_stall; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            chk({n, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({n, "_busy_done"}, {31'd0, in_ready}, 32'd0);
            out_ready = (i == out_stall);
        end
        @(posedge clk);
        #1;
        active = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk({n, "_drained"}, {31'd0, out_valid}, 32'd0);
        chk({n, "_ready_again"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //      name   wen  f3    addr           wdata          rdata          lit_rd         err   wm        wd             rs ds stray
        run_op("lw",   0, 3'd2, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("lb",   0, 3'd0, 32'h8000_0003, 32'h0,         32'h8012_3456, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("lbu",  0, 3'd4, 32'h8000_0003, 32'h0,         32'h8012_3456, 32'h0000_0080, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("lh",   0, 3'd1, 32'h8000_0002, 32'h0,         32'h8012_3456, 32'hFFFF_8012, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("lhu",  0, 3'd5, 32'h8000_0002, 32'h0,         32'h8012_3456, 32'h0000_8012, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("lb1",  0, 3'd0, 32'h8000_0005, 32'h0,         32'h0000_7F00, 32'h0000_007F, 1'b0, 4'b0000, 32'h0,         0, 0, 0);
        run_op("sb",   1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 32'h5555_5555, 32'h0,         1'b0, 4'b0010, 32'h0000_AB00, 0, 0, 0);
        run_op("sh",   1, 3'd1, 32'h8000_0006, 32'h1234_BEEF, 32'h5555_5555, 32'h0,         1'b0, 4'b1100, 32'hBEEF_0000, 0, 0, 0);
        run_op("sw",   1, 3'd2, 32'h8000_0008, 32'hCAFE_F00D, 32'h5555_5555, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 0, 0, 0);
        run_op("lw_mis", 0, 3'd2, 32'h8000_0002, 32'h0,       32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         0, 0, 0);
        run_op("sh_mis", 1, 3'd1, 32'h8000_0003, 32'hFFFF,    32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         0, 0, 0);
        run_op("ld_f3", 0, 3'd3, 32'h8000_0000, 32'h0,        32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         0, 0, 0);
        run_op("ld_f7", 0, 3'd7, 32'h8000_0000, 32'h0,        32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         0, 0, 0);
        run_op("st_f4", 1, 3'd4, 32'h8000_0000, 32'h1,        32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         0, 2, 1);
        run_op("bp",   0, 3'd5, 32'h8000_0000, 32'h0,         32'h1234_ABCD, 32'h0000_ABCD, 1'b0, 4'b0000, 32'h0,         5, 3, 1);
        run_op("bp_sb", 1, 3'd0, 32'h8000_0003, 32'h0000_0077, 32'h0,        32'h0,         1'b0, 4'b1000, 32'h7700_0000, 2, 1, 1);

        // Reset while waiting for the response
        @(negedge clk);
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'd2; in_addr = 32'h8000_0010;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        chk("pre_rst_busy", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_out_rdata", out_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp_out_valid", {31'd0, out_valid}, 32'd0);
        chk("late_rsp_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("late_rsp_out_valid2", {31'd0, out_valid}, 32'd0);
        run_op("post_rst", 0, 3'd2, 32'h8000_0020, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
